// File: rtl/alarm_ringer.sv
// Alarm ring sequencer: turns an alarm-match level into a timed beep with stop,
// auto-timeout and an optional bounded snooze (enabled by ALARM_SNOOZE_EN).
module alarm_ringer #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       tick_1Hz,
  input  logic       tone,
  input  logic       match,
  input  logic       Ctrl,
  input  logic       stop,
  input  logic       snooze,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [3:0] snooze_left,
  output logic [1:0] dbg_state
);

  // Encoding is visible on dbg_state: 0 IDLE, 1 RING, 2 SNOOZE, 3 LOCKOUT.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RING    = 2'd1,
    S_SNOOZE  = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  localparam int RC_W = $clog2(RING_SEC);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RING_SEC - 1);

  state_t          r_state;
  logic            r_match_d;
  logic [RC_W-1:0] r_ring_cnt;
  logic            r_phase;
  logic            r_ringing;
  logic            w_match_rise;

`ifdef ALARM_SNOOZE_EN
  localparam int SC_W = $clog2(SNOOZE_SEC);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SNOOZE_SEC - 1);
  logic [SC_W-1:0] r_snz_cnt;
  logic [3:0]      r_snooze_left;
  logic            r_snoozing;
`endif

  assign w_match_rise = match & ~r_match_d;

  always_ff @(posedge CP) begin
    if (CR) begin
      r_state    <= S_IDLE;
      r_match_d  <= 1'b1;  // a match already present at reset must not ring
      r_ring_cnt <= '0;
      r_phase    <= 1'b0;
      r_ringing  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      r_snz_cnt     <= '0;
      r_snooze_left <= 4'(MAX_SNOOZE);
      r_snoozing    <= 1'b0;
`endif
    end else begin
      r_match_d <= match;
      if (!Ctrl) begin
        r_state    <= S_IDLE;
        r_ring_cnt <= '0;
        r_phase    <= 1'b0;
        r_ringing  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
        r_snz_cnt     <= '0;
        r_snooze_left <= 4'(MAX_SNOOZE);
        r_snoozing    <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_match_rise) begin
              r_state    <= S_RING;
              r_ringing  <= 1'b1;
              r_ring_cnt <= '0;
              r_phase    <= 1'b1;
`ifdef ALARM_SNOOZE_EN
              r_snooze_left <= 4'(MAX_SNOOZE);
`endif
            end
          end
          S_RING: begin
            if (stop) begin
              r_state   <= S_LOCKOUT;
              r_ringing <= 1'b0;
              r_phase   <= 1'b0;
            end
`ifdef ALARM_SNOOZE_EN
            else if (snooze && (r_snooze_left != 4'd0)) begin
              r_state       <= S_SNOOZE;
              r_ringing     <= 1'b0;
              r_snoozing    <= 1'b1;
              r_phase       <= 1'b0;
              r_snz_cnt     <= '0;
              r_snooze_left <= r_snooze_left - 4'd1;
            end
`endif
            else if (tick_1Hz) begin
              if (r_ring_cnt == RC_LAST) begin
                r_state   <= S_LOCKOUT;
                r_ringing <= 1'b0;
                r_phase   <= 1'b0;
              end else begin
                r_ring_cnt <= r_ring_cnt + 1'b1;
                r_phase    <= ~r_phase;
              end
            end
          end
`ifdef ALARM_SNOOZE_EN
          S_SNOOZE: begin
            // Re-ring is purely time-driven; match is deliberately not consulted.
            if (stop) begin
              r_state    <= S_LOCKOUT;
              r_snoozing <= 1'b0;
            end else if (tick_1Hz) begin
              if (r_snz_cnt == SC_LAST) begin
                r_state    <= S_RING;
                r_snoozing <= 1'b0;
                r_ringing  <= 1'b1;
                r_ring_cnt <= '0;
                r_phase    <= 1'b1;
              end else begin
                r_snz_cnt <= r_snz_cnt + 1'b1;
              end
            end
          end
`endif
          S_LOCKOUT: begin
            if (!match) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ringing   = r_ringing;
  assign buzzer    = r_ringing & r_phase & tone;
  assign dbg_state = r_state;

`ifdef ALARM_SNOOZE_EN
  assign snoozing    = r_snoozing;
  assign snooze_left = r_snooze_left;
`else
  assign snoozing    = 1'b0;
  assign snooze_left = 4'd0;
  // Snooze input and its tuning parameters have no function in this build.
  logic w_unused_snooze;
  assign w_unused_snooze = ^{snooze, SNOOZE_SEC[0], MAX_SNOOZE[0]};
`endif

endmodule
